mul_share_ctrl: RTL

//  Sequencer/arbiter that shares one repeated-addition multiplier datapath (A reg, B down-counter, P accumulator) among N_REQ requesters.

---
 rtl/mul_share_ctrl_pkg.sv | 29 ++
 rtl/mul_share_ctrl_rr_arbiter.sv | 29 ++
 rtl/mul_share_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mul_share_ctrl_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM encoding,
// datapath strobe bundle and round-robin index arithmetic.
package mul_share_ctrl_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic ld_p;
        logic clr_p;
        logic dec_b;
    } strobe_t;

    // Slot 'off' positions after 'base' on a ring of n requesters.
    function automatic int rr_slot(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping, returned both one-hot and as an index.
module mul_share_ctrl_rr_arbiter
    import mul_share_ctrl_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!valid && req[rr_slot(int'(ptr), k, N_REQ)]) begin
                valid = 1'b1;
                idx   = ID_W'(rr_slot(int'(ptr), k, N_REQ));
                gnt[rr_slot(int'(ptr), k, N_REQ)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Sequencer that time-shares one repeated-addition multiplier datapath among
// N_REQ requesters: round-robin grant, operand load, accumulate, hand back.
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] op_a,
    input  logic [N_REQ*W-1:0] op_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ack,
    output logic [W-1:0]       result,
    output logic [ID_W-1:0]    result_id,
    output logic               result_vld,
    output logic               busy,
    output logic [W-1:0]       data_out,
    output logic               ldA,
    output logic               ldB,
    output logic               ldP,
    output logic               clrP,
    output logic               decB,
    input  logic               eqz,
    input  logic [W-1:0]       prod_in
);

    if (ID_W != $clog2(N_REQ) || N_REQ < 2 || N_REQ > 8) begin : g_bad_param
        $error("mul_share_ctrl: N_REQ must be 2..8 and ID_W must equal clog2(N_REQ)");
    end

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [W-1:0]       result_q, result_d;
    logic [ID_W-1:0]    result_id_q, result_id_d;

    strobe_t            strb;
    logic [W-1:0]       data_mux;
    logic               done_now;

    logic [N_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_valid;

    logic [W-1:0]       op_a_arr [N_REQ];
    logic [W-1:0]       op_b_arr [N_REQ];

    genvar gi;
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
        assign op_a_arr[gi] = op_a[gi*W +: W];
        assign op_b_arr[gi] = op_b[gi*W +: W];
        assign ack[gi]      = done_now && (id_q == ID_W'(gi));
    end

    mul_share_ctrl_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (req),
        .ptr   (rr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            rr_q        <= '0;
            gnt_q       <= '0;
            result_q    <= '0;
            result_id_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        strb        = '0;
        data_mux    = '0;
        done_now    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    id_d    = arb_idx;
                    state_d = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                strb.ld_a = 1'b1;
                data_mux  = op_a_arr[id_q];
                state_d   = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                strb.ld_b  = 1'b1;
                strb.clr_p = 1'b1;
                data_mux   = op_b_arr[id_q];
                state_d    = ST_ACCUM;
            end
            ST_ACCUM: begin
                // eqz is combinational from the counter, so the last add is
                // suppressed in the very cycle the count reaches zero.
                if (eqz) begin
                    state_d = ST_DONE;
                end else begin
                    strb.ld_p  = 1'b1;
                    strb.dec_b = 1'b1;
                end
            end
            ST_DONE: begin
                done_now    = 1'b1;
                result_d    = prod_in;
                result_id_d = id_q;
                rr_d        = ID_W'(rr_slot(int'(id_q), 1, N_REQ));
                gnt_d       = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The product is forwarded during DONE so it is valid alongside the
    // result_vld/ack pulse; the registered copy holds it afterwards.
    assign result     = done_now ? prod_in : result_q;
    assign result_id  = done_now ? id_q : result_id_q;
    assign result_vld = done_now;
    assign busy       = (state_q != ST_IDLE);
    assign gnt        = gnt_q;
    assign data_out   = data_mux;
    assign ldA        = strb.ld_a;
    assign ldB        = strb.ld_b;
    assign ldP        = strb.ld_p;
    assign clrP       = strb.clr_p;
    assign decB       = strb.dec_b;

endmodule
